key_debounce_array: RTL and testbench

- Parametrised N-channel key/button conditioner that succeeds the fixed 4-input, fixed-threshold key interrupt generator.
- Each channel synchronises a raw input, debounces it symmetrically in both directions, and emits single-cycle press, release and auto-repeat events.
- Each channel also keeps a sticky, maskable interrupt-pending bit for the CPU-facing peripheral wrapper.
- Sits between the board pins and the AHB/APB key peripheral.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_debounce_array_if.sv | 25 ++
 rtl/key_debounce_chan.sv | 108 ++++++++++
 rtl/key_debounce_array.sv | 60 ++++++
 tb/tb_key_debounce_array.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared channel state type and board-clock timing defaults
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_fsm_e;

    // 50 MHz board clock: ~82 us debounce, 100 ms to first repeat, 20 ms repeat period
    localparam int DEF_DEB_CYCLES    = 4095;
    localparam int DEF_LONG_CYCLES   = 5000000;
    localparam int DEF_REPEAT_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce_array_if.sv
// rtl/key_debounce_array_if.sv - key conditioner signal bundle
interface key_debounce_array_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic                repeat_en;
    logic [NUM_KEYS-1:0] irq_en;
    logic [NUM_KEYS-1:0] irq_clr;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] repeat_pulse;
    logic [NUM_KEYS-1:0] irq_pending;
    logic                irq;

    modport master (
        output key_in, repeat_en, irq_en, irq_clr,
        input  key_state, press_pulse, release_pulse, repeat_pulse, irq_pending, irq
    );

    modport slave (
        input  key_in, repeat_en, irq_en, irq_clr,
        output key_state, press_pulse, release_pulse, repeat_pulse, irq_pending, irq
    );
endinterface

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - one key channel: synchroniser, debounce, hold/repeat FSM
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_W        = 24,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic key_in,
    input  logic repeat_en,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic              IDLE_LVL  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [1:0]        sync_ff;
    logic              sync;
    logic [CNT_W-1:0]  deb_cnt;
    logic              accept;
    logic              freeze;
    key_fsm_e          state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              fire;

    // Sync flops reset to the released pin level so an active-low key does not self-press
    assign sync   = IDLE_LVL ? ~sync_ff[1] : sync_ff[1];
    assign accept = (sync != key_state) && (deb_cnt == DEB_LAST);
    assign freeze = (deb_cnt != '0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync_ff       <= {2{IDLE_LVL}};
            deb_cnt       <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_ff       <= {sync_ff[0], key_in};
            press_pulse   <= accept & ~key_state;
            release_pulse <= accept & key_state;
            if (accept) begin
                key_state <= ~key_state;
                deb_cnt   <= '0;
            end else if (sync == key_state) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !key_state) begin
                    state_next = HELD;
                    hold_next  = '0;
                end
            end
            HELD, REPEAT: begin
                if (accept) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (!freeze) begin
                    // Hold time stalls while a possible release is still being debounced
                    if (hold_cnt == ((state == HELD) ? LONG_LAST : REP_LAST)) begin
                        state_next = REPEAT;
                        hold_next  = '0;
                        fire       = 1'b1;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            repeat_pulse <= fire & repeat_en;
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - N-channel key conditioner with sticky maskable interrupts
module key_debounce_array
    import key_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int CNT_W         = 12,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_W        = 24,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    key_debounce_array_if.slave  bus
);

    logic [NUM_KEYS-1:0] state_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] release_vec;
    logic [NUM_KEYS-1:0] repeat_vec;
    logic [NUM_KEYS-1:0] pending;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .CNT_W         (CNT_W),
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_W        (HOLD_W),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .HCLK          (HCLK),
            .HRESET        (HRESET),
            .key_in        (bus.key_in[i]),
            .repeat_en     (bus.repeat_en),
            .key_state     (state_vec[i]),
            .press_pulse   (press_vec[i]),
            .release_pulse (release_vec[i]),
            .repeat_pulse  (repeat_vec[i])
        );
    end

    // A new event in the same cycle as a clear keeps the bit set
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~bus.irq_clr) | press_vec | release_vec | repeat_vec;
        end
    end

    assign bus.key_state     = state_vec;
    assign bus.press_pulse   = press_vec;
    assign bus.release_pulse = release_vec;
    assign bus.repeat_pulse  = repeat_vec;
    assign bus.irq_pending   = pending;
    assign bus.irq           = |(pending & bus.irq_en);

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - directed and random checks of key_debounce_array against a reference model
module tb_key_debounce_array;

    localparam int NK   = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int REP  = 16;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    key_debounce_array_if #(.NUM_KEYS(NK)) bus ();

    key_debounce_array #(
        .NUM_KEYS      (NK),
        .CNT_W         (12),
        .DEB_CYCLES    (DEB),
        .HOLD_W        (24),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .ACTIVE_LOW    (0)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Model: raw samples per edge (newest first), accepted level, hold time since press
    int              hist [NK][DEB+3];
    logic [NK-1:0]   m_ks, m_held, m_press, m_rel, m_rep, m_pend;
    int              m_ht [NK];
    int              n_press [NK];
    int              n_rel [NK];
    int              n_rep [NK];

    function automatic void model_reset();
        for (int i = 0; i < NK; i++) begin
            for (int j = 0; j < DEB + 3; j++) hist[i][j] = 0;
            m_ht[i] = 0;
        end
        m_ks = '0; m_held = '0; m_press = '0; m_rel = '0; m_rep = '0; m_pend = '0;
    endfunction

    function automatic void model_edge();
        m_pend = (m_pend & ~bus.irq_clr) | m_press | m_rel | m_rep;
        for (int i = 0; i < NK; i++) begin
            logic stable;
            logic frozen;
            for (int j = DEB + 2; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = int'(bus.key_in[i]);
            stable = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (hist[i][j] == int'(m_ks[i])) stable = 1'b0;
            frozen = (hist[i][3] != int'(m_ks[i]));
            m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
            if (stable) begin
                m_ks[i] = ~m_ks[i];
                if (m_ks[i]) begin
                    m_press[i] = 1'b1; m_held[i] = 1'b1; m_ht[i] = 0;
                end else begin
                    m_rel[i] = 1'b1; m_held[i] = 1'b0;
                end
            end else if (m_held[i] && !frozen) begin
                m_ht[i]++;
                if (m_ht[i] == LONG || (m_ht[i] > LONG && (m_ht[i] - LONG) % REP == 0))
                    m_rep[i] = bus.repeat_en;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("key_state", 32'(bus.key_state), 32'(m_ks));
        chk("press_pulse", 32'(bus.press_pulse), 32'(m_press));
        chk("release_pulse", 32'(bus.release_pulse), 32'(m_rel));
        chk("repeat_pulse", 32'(bus.repeat_pulse), 32'(m_rep));
        chk("irq_pending", 32'(bus.irq_pending), 32'(m_pend));
        chk("irq", 32'(bus.irq), 32'(|(m_pend & bus.irq_en)));
        for (int i = 0; i < NK; i++) begin
            n_press[i] += int'(bus.press_pulse[i]);
            n_rel[i]   += int'(bus.release_pulse[i]);
            n_rep[i]   += int'(bus.repeat_pulse[i]);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        if (HRESET) model_reset();
        else        model_edge();
        @(negedge HCLK);
        check_all();
    endtask

    function automatic logic pulse_of(input int ch, input int kind);
        case (kind)
            0:       return bus.press_pulse[ch];
            1:       return bus.release_pulse[ch];
            default: return bus.repeat_pulse[ch];
        endcase
    endfunction

    // n = edge count at which the pulse is first seen, -1 if the bound expires
    task automatic wait_pulse(input int ch, input int kind, input int bound, output int n);
        n = -1;
        for (int t = 1; t <= bound; t++) begin
            tick();
            if (pulse_of(ch, kind)) begin
                n = t;
                break;
            end
        end
    endtask

    initial begin
        int n, cnt, first, p0, r0;
        int cd [NK];

        bus.key_in = '0; bus.repeat_en = 1'b1; bus.irq_en = '0; bus.irq_clr = '0;
        for (int i = 0; i < NK; i++) begin n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; end
        model_reset();
        repeat (3) tick();
        HRESET = 1'b0;
        repeat (5) tick();

        // Clean press and long-press repeat schedule
        bus.irq_en = 4'b0001;
        bus.key_in[0] = 1'b1;
        wait_pulse(0, 0, 40, n);
        chk("press0_latency", n, 10);
        chk("press0_state", 32'(bus.key_state[0]), 1);
        tick();
        chk("press0_single", 32'(bus.press_pulse[0]), 0);
        chk("press0_pending", 32'(bus.irq_pending[0]), 1);
        chk("press0_irq", 32'(bus.irq), 1);
        cnt = 0; first = -1;
        for (int t = 2; t <= 100; t++) begin
            tick();
            if (bus.repeat_pulse[0]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
        chk("repeat_count_en", cnt, 5);
        chk("repeat_first", first, 32);
        bus.key_in[0] = 1'b0;
        wait_pulse(0, 1, 40, n);
        chk("release0_latency", n, 10);

        bus.repeat_en = 1'b0;
        bus.key_in[0] = 1'b1;
        wait_pulse(0, 0, 40, n);
        cnt = 0;
        repeat (100) begin
            tick();
            if (bus.repeat_pulse[0]) cnt++;
        end
        chk("repeat_count_dis", cnt, 0);
        chk("held_state_dis", 32'(bus.key_state[0]), 1);
        bus.key_in[0] = 1'b0;
        wait_pulse(0, 1, 40, n);
        bus.repeat_en = 1'b1;

        // Bouncing key1
        p0 = n_press[1]; r0 = n_rel[1];
        for (int k = 0; k < 10; k++) begin
            bus.key_in[1] = (k % 2 == 0);
            repeat (3) tick();
        end
        bus.key_in[1] = 1'b1;
        wait_pulse(1, 0, 40, n);
        chk("bounce_latency", n, 10);
        chk("bounce_press_count", n_press[1] - p0, 1);
        chk("bounce_release_count", n_rel[1] - r0, 0);

        // Key2: 3-cycle low glitch delays repeat by 3, then a real release
        bus.key_in[2] = 1'b1;
        wait_pulse(2, 0, 40, n);
        r0 = n_rel[2];
        repeat (10) tick();
        bus.key_in[2] = 1'b0;
        repeat (3) tick();
        bus.key_in[2] = 1'b1;
        first = -1;
        for (int t = 14; t <= 60; t++) begin
            tick();
            if (bus.repeat_pulse[2]) begin
                first = t;
                break;
            end
        end
        chk("glitch_first_repeat", first, 35);
        chk("glitch_no_release", n_rel[2] - r0, 0);
        bus.key_in[2] = 1'b0;
        wait_pulse(2, 1, 40, n);
        chk("release2_latency", n, 10);
        chk("release2_state", 32'(bus.key_state[2]), 0);

        // Pending set/clear priority and masking
        bus.repeat_en = 1'b0;
        repeat (2) tick();
        bus.irq_clr = '1;
        tick();
        bus.irq_clr = '0;
        chk("pending_cleared", 32'(bus.irq_pending), 0);
        bus.key_in[0] = 1'b1;
        wait_pulse(0, 0, 40, n);
        bus.irq_clr[0] = 1'b1;
        tick();
        bus.irq_clr[0] = 1'b0;
        chk("set_wins", 32'(bus.irq_pending[0]), 1);
        bus.irq_clr[0] = 1'b1;
        tick();
        bus.irq_clr[0] = 1'b0;
        chk("clear_alone", 32'(bus.irq_pending[0]), 0);
        bus.key_in[0] = 1'b0;
        wait_pulse(0, 1, 40, n);
        bus.irq_en = '0;
        tick();
        chk("irq_masked", 32'(bus.irq), 0);
        chk("pending_masked", 32'(bus.irq_pending[0]), 1);

        // Asynchronous reset while key3 is held
        bus.irq_en = '1; bus.repeat_en = 1'b1;
        bus.key_in[3] = 1'b1;
        wait_pulse(3, 0, 40, n);
        repeat (5) tick();
        #2 HRESET = 1'b1;
        #1 model_reset();
        check_all();
        repeat (2) tick();
        HRESET = 1'b0;
        wait_pulse(3, 0, 40, n);
        chk("post_reset_press", n, 10);
        bus.key_in[3] = 1'b0;
        wait_pulse(3, 1, 40, n);
        repeat (3) tick();
        bus.key_in[0] = 1'b1; bus.key_in[3] = 1'b1;
        wait_pulse(0, 0, 40, n);
        chk("simul_press0", n, 10);
        chk("simul_press3", 32'(bus.press_pulse[3]), 1);

        // Random dwell times on every key, random clears/masks
        for (int i = 0; i < NK; i++) cd[i] = $urandom_range(1, 70);
        repeat (2000) begin
            for (int i = 0; i < NK; i++) begin
                if (cd[i] == 0) begin
                    bus.key_in[i] = ~bus.key_in[i];
                    cd[i] = $urandom_range(1, 70);
                end else begin
                    cd[i]--;
                end
            end
            bus.irq_clr = NK'($urandom & $urandom);
            if ($urandom_range(0, 49) == 0)  bus.irq_en = NK'($urandom);
            if ($urandom_range(0, 199) == 0) bus.repeat_en = ~bus.repeat_en;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
